// File: rtl/neo_rx.sv
// NeoPixel (WS2812-style) serial receiver: pulse-width bit decode, 24-bit GRB
// pixel assembly, latch-gap framing and sticky error reporting.
module neo_rx #(
  parameter int unsigned BIT_THRESH   = 26,
  parameter int unsigned MIN_HIGH     = 8,
  parameter int unsigned MAX_HIGH     = 60,
  parameter int unsigned LATCH_CYCLES = 2500,
  parameter int unsigned NUM_PIXELS   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        neo_in,
  input  logic        clear_err,
  output logic [23:0] pixel_data,
  output logic [2:0]  pixel_index,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic [3:0]  frame_pixels,
  output logic [3:0]  error
);

  localparam int unsigned HW = $clog2(MAX_HIGH + 1);
  localparam int unsigned LW = $clog2(LATCH_CYCLES + 1);
  localparam int unsigned PW = $clog2(NUM_PIXELS + 1);

  localparam logic [HW-1:0] HIGH_MIN    = HW'(MIN_HIGH);
  localparam logic [HW-1:0] HIGH_BIT    = HW'(BIT_THRESH);
  localparam logic [HW-1:0] HIGH_MAX    = HW'(MAX_HIGH);
  localparam logic [HW-1:0] HIGH_MAX_M1 = HW'(MAX_HIGH - 1);
  localparam logic [LW-1:0] LATCH_M1    = LW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] PIX_MAX     = PW'(NUM_PIXELS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_e;

  state_e        state, state_d;
  logic [1:0]    sync_q;
  logic          line;
  logic [HW-1:0] high_cnt, high_cnt_d;
  logic [LW-1:0] low_cnt, low_cnt_d;
  logic [4:0]    bit_cnt, bit_cnt_d;
  logic [22:0]   shift, shift_d;
  logic [PW-1:0] pix_cnt, pix_cnt_d;
  logic [23:0]   pixel_data_d;
  logic [2:0]    pixel_index_d;
  logic          pixel_valid_d, frame_done_d;
  logic [3:0]    frame_pixels_d, error_d, err_set;
  logic          bit_val;

  assign line    = sync_q[1];
  assign bit_val = (high_cnt >= HIGH_BIT);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= SYNC;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      SYNC: if (!line && low_cnt == LATCH_M1) state_d = IDLE;
      IDLE: if (line) state_d = HIGH;
      HIGH: begin
        if (line) begin
          if (high_cnt == HIGH_MAX_M1) state_d = SYNC;
        end else if (high_cnt < HIGH_MIN) begin
          state_d = SYNC;
        end else begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (line)                      state_d = HIGH;
        else if (low_cnt == LATCH_M1)  state_d = IDLE;
      end
      default: state_d = SYNC;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    high_cnt_d     = high_cnt;
    low_cnt_d      = low_cnt;
    bit_cnt_d      = bit_cnt;
    shift_d        = shift;
    pix_cnt_d      = pix_cnt;
    pixel_data_d   = pixel_data;
    pixel_index_d  = pixel_index;
    frame_pixels_d = frame_pixels;
    pixel_valid_d  = 1'b0;
    frame_done_d   = 1'b0;
    err_set        = 4'b0000;
    case (state)
      SYNC: begin
        high_cnt_d = '0;
        bit_cnt_d  = '0;
        shift_d    = '0;
        if (line || low_cnt == LATCH_M1) low_cnt_d = '0;
        else                             low_cnt_d = low_cnt + LW'(1);
      end
      IDLE: begin
        if (line) begin
          high_cnt_d = HW'(1);
          low_cnt_d  = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
          pix_cnt_d  = '0;
        end
      end
      HIGH: begin
        if (line) begin
          if (high_cnt == HIGH_MAX_M1) begin
            err_set[1] = 1'b1;
            high_cnt_d = '0;
            low_cnt_d  = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
          end else if (high_cnt != HIGH_MAX) begin
            high_cnt_d = high_cnt + HW'(1);
          end
        end else if (high_cnt < HIGH_MIN) begin
          err_set[0] = 1'b1;
          high_cnt_d = '0;
          low_cnt_d  = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
        end else begin
          high_cnt_d = '0;
          low_cnt_d  = LW'(1);
          shift_d    = {shift[21:0], bit_val};
          if (bit_cnt == 5'd23) begin
            bit_cnt_d = '0;
            if (pix_cnt < PIX_MAX) begin
              pixel_data_d  = {shift, bit_val};
              pixel_index_d = 3'(pix_cnt);
              pixel_valid_d = 1'b1;
              pix_cnt_d     = pix_cnt + PW'(1);
            end else begin
              err_set[3] = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt + 5'd1;
          end
        end
      end
      LOW: begin
        if (line) begin
          high_cnt_d = HW'(1);
          low_cnt_d  = '0;
        end else if (low_cnt == LATCH_M1) begin
          frame_done_d   = 1'b1;
          frame_pixels_d = 4'(pix_cnt);
          err_set[2]     = (bit_cnt != 5'd0);
          low_cnt_d      = '0;
          bit_cnt_d      = '0;
          shift_d        = '0;
        end else begin
          low_cnt_d = low_cnt + LW'(1);
        end
      end
      default: ;
    endcase
    // A clear coinciding with a new error keeps the new bit.
    error_d = (clear_err ? 4'b0000 : error) | err_set;
  end

  // Synchronizer, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q       <= '0;
      high_cnt     <= '0;
      low_cnt      <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      pix_cnt      <= '0;
      pixel_data   <= '0;
      pixel_index  <= '0;
      pixel_valid  <= 1'b0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      error        <= '0;
    end else begin
      sync_q       <= {sync_q[0], neo_in};
      high_cnt     <= high_cnt_d;
      low_cnt      <= low_cnt_d;
      bit_cnt      <= bit_cnt_d;
      shift        <= shift_d;
      pix_cnt      <= pix_cnt_d;
      pixel_data   <= pixel_data_d;
      pixel_index  <= pixel_index_d;
      pixel_valid  <= pixel_valid_d;
      frame_done   <= frame_done_d;
      frame_pixels <= frame_pixels_d;
      error        <= error_d;
    end
  end

endmodule

// File: tb/tb_neo_rx.sv
// Directed self-checking bench for neo_rx: framing, overflow, glitch,
// partial-pixel, stuck-high and mid-pixel reset scenarios.
module tb_neo_rx;

  logic        clock = 1'b0;
  logic        reset;
  logic        neo_in;
  logic        clear_err;
  logic [23:0] pixel_data;
  logic [2:0]  pixel_index;
  logic        pixel_valid;
  logic        frame_done;
  logic [3:0]  frame_pixels;
  logic [3:0]  error;

  neo_rx dut (
    .clock(clock), .reset(reset), .neo_in(neo_in), .clear_err(clear_err),
    .pixel_data(pixel_data), .pixel_index(pixel_index), .pixel_valid(pixel_valid),
    .frame_done(frame_done), .frame_pixels(frame_pixels), .error(error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fall_cyc = 0;

  // Strobe monitor, sampled on the falling edge away from register updates
  int          pv_cnt = 0;
  int          fd_cnt = 0;
  int          pv_cyc = 0;
  int          fd_cyc = 0;
  logic [23:0] pv_data [32];
  logic [2:0]  pv_idx  [32];
  logic        both_seen = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pixel_valid) begin
      if (pv_cnt < 32) begin
        pv_data[pv_cnt] = pixel_data;
        pv_idx[pv_cnt]  = pixel_index;
      end
      pv_cnt = pv_cnt + 1;
      pv_cyc = cyc;
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
    if (pixel_valid && frame_done) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    neo_in = 1'b1;
    repeat (b ? 35 : 18) @(negedge clock);
    neo_in = 1'b0;
    fall_cyc = cyc;
    repeat (b ? 30 : 40) @(negedge clock);
  endtask

  task automatic send_bits(input logic [23:0] p, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(p[i]);
  endtask

  task automatic gap(input int n);
    neo_in = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_clear;
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},   32'(pixel_data),   32'h0);
    check({tag, "_index"},  32'(pixel_index),  32'h0);
    check({tag, "_valid"},  32'(pixel_valid),  32'h0);
    check({tag, "_done"},   32'(frame_done),   32'h0);
    check({tag, "_fpix"},   32'(frame_pixels), 32'h0);
    check({tag, "_error"},  32'(error),        32'h0);
  endtask

  int pv_base, fd_base;

  initial begin
    reset = 1'b1; neo_in = 1'b0; clear_err = 1'b0;
    repeat (4) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;

    // Initial sync gap must not produce frame_done
    gap(2600);
    check("sync_no_done", 32'(fd_cnt), 32'd0);

    // Single pixel 0xFF0000
    pv_base = pv_cnt; fd_base = fd_cnt;
    send_bits(24'hFF0000, 24);
    gap(2500);
    check("p1_count", 32'(pv_cnt - pv_base), 32'd1);
    check("p1_data",  32'(pv_data[pv_base]), 32'hFF0000);
    check("p1_index", 32'(pv_idx[pv_base]), 32'd0);
    check("p1_valid_lat", 32'(pv_cyc - fall_cyc), 32'd3);
    check("p1_done_count", 32'(fd_cnt - fd_base), 32'd1);
    check("p1_done_lat", 32'(fd_cyc - fall_cyc), 32'd2502);
    check("p1_fpix", 32'(frame_pixels), 32'd1);
    check("p1_error", 32'(error), 32'h0);
    check("p1_data_hold", 32'(pixel_data), 32'hFF0000);

    // Full frame of 8 pixels
    pv_base = pv_cnt;
    for (int p = 1; p <= 8; p++) send_bits(24'(p), 24);
    gap(2500);
    check("f8_count", 32'(pv_cnt - pv_base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("f8_data%0d", i),  32'(pv_data[pv_base + i]), 32'(i + 1));
      check($sformatf("f8_index%0d", i), 32'(pv_idx[pv_base + i]),  32'(i));
    end
    check("f8_fpix", 32'(frame_pixels), 32'd8);
    check("f8_error", 32'(error), 32'h0);

    // Overflow: 9 pixels
    pv_base = pv_cnt;
    for (int p = 0; p < 9; p++) send_bits(24'h100000 + 24'(p), 24);
    gap(2500);
    check("ovf_count", 32'(pv_cnt - pv_base), 32'd8);
    check("ovf_error", 32'(error), 32'h8);
    check("ovf_fpix", 32'(frame_pixels), 32'd8);
    pulse_clear();
    check("ovf_clear", 32'(error), 32'h0);

    // Glitch mid-pixel, then a pixel before any latch gap is ignored
    pv_base = pv_cnt; fd_base = fd_cnt;
    send_bits(24'hA5A5A5, 12);
    neo_in = 1'b1;
    repeat (4) @(negedge clock);
    neo_in = 1'b0;
    repeat (40) @(negedge clock);
    check("gl_error", 32'(error), 32'h1);
    send_bits(24'h123456, 24);
    gap(2500);
    check("gl_no_pixel", 32'(pv_cnt - pv_base), 32'd0);
    check("gl_no_done", 32'(fd_cnt - fd_base), 32'd0);
    send_bits(24'hABCDEF, 24);
    gap(2500);
    check("gl_after_count", 32'(pv_cnt - pv_base), 32'd1);
    check("gl_after_data", 32'(pv_data[pv_base]), 32'hABCDEF);
    check("gl_after_fpix", 32'(frame_pixels), 32'd1);
    check("gl_sticky", 32'(error), 32'h1);
    pulse_clear();
    check("gl_clear", 32'(error), 32'h0);

    // Partial pixel at frame end
    pv_base = pv_cnt; fd_base = fd_cnt;
    send_bits(24'hFFF000, 12);
    gap(2500);
    check("part_no_pixel", 32'(pv_cnt - pv_base), 32'd0);
    check("part_done", 32'(fd_cnt - fd_base), 32'd1);
    check("part_fpix", 32'(frame_pixels), 32'd0);
    check("part_error", 32'(error), 32'h4);
    pulse_clear();
    check("part_clear", 32'(error), 32'h0);

    // Stuck-high line
    neo_in = 1'b1;
    repeat (70) @(negedge clock);
    neo_in = 1'b0;
    check("stuck_error", 32'(error), 32'h2);
    gap(2600);

    // Reset mid-pixel discards everything
    pv_base = pv_cnt; fd_base = fd_cnt;
    send_bits(24'hC3C3C3, 12);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_all_zero("mid_reset");
    reset = 1'b0;
    for (int i = 11; i >= 0; i--) send_bit(i[0]);
    gap(2600);
    check("rst_no_pixel", 32'(pv_cnt - pv_base), 32'd0);
    check("rst_no_done", 32'(fd_cnt - fd_base), 32'd0);
    check("rst_fpix", 32'(frame_pixels), 32'd0);
    check("rst_error", 32'(error), 32'h0);

    check("never_both", 32'(both_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
